// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution writeback path.
package conv_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PLANE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Negative sums clamp to zero; non-negative sums pass through at full width.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Registered show-ahead FIFO: dout always presents the head entry while not empty.
module sync_fifo
    import conv_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // A pop frees the slot being filled, so push on full succeeds when paired with a pop.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= din;
                r_wr_ptr                <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/acc_writeback.sv
// Buffers ReLU'd window sums and writes them to output memory, tracking planes per layer.
module acc_writeback
    import conv_pkg::*;
#(
    parameter int unsigned OUT_PER_PLANE = 24,
    parameter int unsigned NUM_PLANES    = 6,
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   sum,
    input  logic                sum_vld,
    input  logic                mem_rdy,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic                plane_rdy,
    output logic [PLANE_W-1:0]  plane_idx,
    output logic                busy,
    output logic                done,
    output logic                ovf
);

    localparam int unsigned CNT_W = (OUT_PER_PLANE > 1) ? $clog2(OUT_PER_PLANE) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [CNT_W-1:0]    r_cnt;
    logic [PLANE_W-1:0]  r_plane;
    logic                r_plane_rdy;
    logic                r_done;
    logic                r_ovf;

    logic                w_run;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;
    logic                w_enter_run;
    logic                w_last_in_plane;
    logic                w_last_plane;
    logic [DATA_W-1:0]   w_head;

    assign w_run           = (r_state == RUN);
    assign w_pop           = !w_empty && mem_rdy;
    assign w_push          = w_run && sum_vld && (!w_full || w_pop);
    assign w_drop          = w_run && sum_vld && w_full && !w_pop;
    assign w_enter_run     = start && (r_state != RUN);
    assign w_last_in_plane = (r_cnt == CNT_W'(OUT_PER_PLANE - 1));
    assign w_last_plane    = (r_plane == PLANE_W'(NUM_PLANES - 1));

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (relu(sum)),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_pop && w_last_in_plane && w_last_plane) w_state_nxt = DONE;
            DONE:    if (start) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Address, plane bookkeeping and sticky status; a layer start clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_cnt       <= '0;
            r_plane     <= '0;
            r_plane_rdy <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_enter_run) begin
            r_addr      <= '0;
            r_cnt       <= '0;
            r_plane     <= '0;
            r_plane_rdy <= 1'b0;
            r_done      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_plane_rdy <= w_pop && w_last_in_plane;
            if (w_pop) begin
                r_addr <= r_addr + ADDR_W'(1);
                if (w_last_in_plane) begin
                    r_cnt   <= '0;
                    r_plane <= w_last_plane ? '0 : r_plane + PLANE_W'(1);
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_run && (w_state_nxt == DONE)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign wr_en     = !w_empty;
    assign wr_data   = w_head;
    assign wr_addr   = r_addr;
    assign plane_rdy = r_plane_rdy;
    assign plane_idx = r_plane;
    assign busy      = w_run;
    assign done      = r_done;
    assign ovf       = r_ovf;

endmodule
